// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - shared types and constants for the store buffer
package sb_pkg;

    localparam int SB_DM_ADDRESS = 9;
    localparam int SB_DATA_W     = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FENCE = 2'd1,
        ST_DONE  = 2'd2
    } sb_state_e;

    typedef struct packed {
        logic [SB_DM_ADDRESS-1:0] addr;
        logic [SB_DATA_W-1:0]     data;
        logic [2:0]               funct3;
    } sb_entry_t;

endpackage

// File: rtl/sb_fwd_match.sv
// rtl/sb_fwd_match.sv - youngest resident entry whose word address matches a load
module sb_fwd_match
    import sb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WW    = SB_DM_ADDRESS - 2
) (
    input  logic [WW-1:0]              i_words [DEPTH],
    input  logic                       i_is_sw [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   i_head,
    input  logic [$clog2(DEPTH):0]     i_count,
    input  logic [WW-1:0]              i_ld_word,
    input  logic                       i_ld_is_lw,
    output logic [$clog2(DEPTH)-1:0]   o_hit_idx,
    output logic                       o_hit_valid,
    output logic                       o_fwd_ok
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Walk oldest to youngest so the last match found is the youngest one.
    always_comb begin
        logic [PW-1:0] w_idx;
        o_hit_valid = 1'b0;
        o_hit_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_head + PW'(i);
            if ((CW'(i) < i_count) && (i_words[w_idx] == i_ld_word)) begin
                o_hit_valid = 1'b1;
                o_hit_idx   = w_idx;
            end
        end
        o_fwd_ok = o_hit_valid && i_is_sw[o_hit_idx] && i_ld_is_lw;
    end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store buffer with load forwarding and fence drain
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DM_ADDRESS = SB_DM_ADDRESS,
    parameter int DATA_W     = SB_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       st_valid,
    input  logic [DM_ADDRESS-1:0]      st_addr,
    input  logic [DATA_W-1:0]          st_data,
    input  logic [2:0]                 st_funct3,
    output logic                       st_ready,
    input  logic                       ld_valid,
    input  logic [DM_ADDRESS-1:0]      ld_addr,
    input  logic [2:0]                 ld_funct3,
    output logic                       fwd_hit,
    output logic [DATA_W-1:0]          fwd_data,
    output logic                       ld_stall,
    input  logic                       fence,
    output logic                       fence_done,
    output logic                       mem_MemRead,
    output logic                       mem_MemWrite,
    output logic [DM_ADDRESS-1:0]      mem_a,
    output logic [DATA_W-1:0]          mem_wd,
    output logic [2:0]                 mem_Funct3,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int WW = DM_ADDRESS - 2;

    sb_entry_t          r_mem [DEPTH];
    logic [PW-1:0]      r_head;
    logic [PW-1:0]      r_tail;
    logic [CW-1:0]      r_count;
    sb_state_e          r_state;

    logic [WW-1:0]      w_words [DEPTH];
    logic               w_is_sw [DEPTH];
    logic [PW-1:0]      w_hit_idx;
    logic               w_hit_valid;
    logic               w_fwd_ok;
    logic               w_full;
    logic               w_empty;
    logic               w_enq;
    logic               w_ld_active;
    logic               w_ld_port;
    logic               w_drain;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_words[i] = r_mem[i].addr[DM_ADDRESS-1:2];
            w_is_sw[i] = (r_mem[i].funct3 == SW);
        end
    end

    sb_fwd_match #(
        .DEPTH (DEPTH),
        .WW    (WW)
    ) u_match (
        .i_words     (w_words),
        .i_is_sw     (w_is_sw),
        .i_head      (r_head),
        .i_count     (r_count),
        .i_ld_word   (ld_addr[DM_ADDRESS-1:2]),
        .i_ld_is_lw  (ld_funct3 == LW),
        .o_hit_idx   (w_hit_idx),
        .o_hit_valid (w_hit_valid),
        .o_fwd_ok    (w_fwd_ok)
    );

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Outputs that depend on live inputs are held low while reset is asserted.
    assign w_enq       = st_valid && st_ready;
    assign w_ld_active = rst_n && ld_valid;
    assign w_ld_port   = w_ld_active && !w_hit_valid;
    assign w_drain     = rst_n && !w_ld_port && !w_empty;

    assign st_ready   = rst_n && !w_full && (r_state == ST_RUN);
    assign fwd_hit    = w_ld_active && w_hit_valid && w_fwd_ok;
    assign ld_stall   = w_ld_active && w_hit_valid && !w_fwd_ok;
    assign fwd_data   = fwd_hit ? r_mem[w_hit_idx].data : '0;
    assign fence_done = (r_state == ST_DONE);
    assign count      = r_count;
    assign full       = w_full;
    assign empty      = w_empty;

    always_comb begin
        mem_MemRead  = 1'b0;
        mem_MemWrite = 1'b0;
        mem_a        = '0;
        mem_wd       = '0;
        mem_Funct3   = '0;
        if (w_ld_port) begin
            mem_MemRead = 1'b1;
            mem_a       = ld_addr;
            mem_Funct3  = ld_funct3;
        end else if (w_drain) begin
            mem_MemWrite = 1'b1;
            mem_a        = r_mem[r_head].addr;
            mem_wd       = r_mem[r_head].data;
            mem_Funct3   = r_mem[r_head].funct3;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_tail] <= '{addr: st_addr, data: st_data, funct3: st_funct3};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= ST_RUN;
        end else begin
            if (w_enq) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_drain) begin
                r_head <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_enq) - CW'(w_drain);
            case (r_state)
                ST_RUN: begin
                    if (fence) begin
                        r_state <= ST_FENCE;
                    end
                end
                ST_FENCE: begin
                    if (w_empty) begin
                        r_state <= ST_DONE;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized and directed checks of store_buffer against a queue model
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [8:0]  st_addr;
    logic [31:0] st_data;
    logic [2:0]  st_funct3;
    logic        st_ready;
    logic        ld_valid;
    logic [8:0]  ld_addr;
    logic [2:0]  ld_funct3;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic        ld_stall;
    logic        fence;
    logic        fence_done;
    logic        mem_MemRead;
    logic        mem_MemWrite;
    logic [8:0]  mem_a;
    logic [31:0] mem_wd;
    logic [2:0]  mem_Funct3;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    store_buffer #(.DEPTH(DEPTH), .DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .ld_stall(ld_stall),
        .fence(fence), .fence_done(fence_done),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_a(mem_a),
        .mem_wd(mem_wd), .mem_Funct3(mem_Funct3),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } ent_t;

    ent_t q[$];
    int   m_mode;
    int   n_checks;
    int   n_fail;

    logic        e_st_ready, e_fwd_hit, e_ld_stall, e_rd, e_wr, e_fd;
    logic [31:0] e_fwd_data, e_wd;
    logic [8:0]  e_a;
    logic [2:0]  e_f3;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle, derived from the queue contents.
    task automatic eval();
        bit          hit, fwdable;
        logic [31:0] hd;
        #1;
        hit = 0; fwdable = 0; hd = '0;
        if (ld_valid) begin
            for (int k = q.size() - 1; k >= 0; k--) begin
                if (q[k].addr[8:2] == ld_addr[8:2]) begin
                    hit = 1;
                    fwdable = (q[k].f3 == 3'b010) && (ld_funct3 == 3'b010);
                    hd = q[k].data;
                    break;
                end
            end
        end
        e_st_ready = (q.size() < DEPTH) && (m_mode == 0);
        e_fwd_hit  = hit && fwdable;
        e_ld_stall = hit && !fwdable;
        e_fwd_data = e_fwd_hit ? hd : 32'd0;
        e_rd       = ld_valid && !hit;
        e_wr       = !e_rd && (q.size() > 0);
        e_a        = e_rd ? ld_addr : (e_wr ? q[0].addr : 9'd0);
        e_wd       = e_wr ? q[0].data : 32'd0;
        e_f3       = e_rd ? ld_funct3 : (e_wr ? q[0].f3 : 3'd0);
        e_fd       = (m_mode == 2);
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("st_ready", st_ready, e_st_ready);
        chk("fwd_hit", fwd_hit, e_fwd_hit);
        chk("fwd_data", fwd_data, e_fwd_data);
        chk("ld_stall", ld_stall, e_ld_stall);
        chk("mem_MemRead", mem_MemRead, e_rd);
        chk("mem_MemWrite", mem_MemWrite, e_wr);
        chk("mem_a", mem_a, e_a);
        chk("mem_wd", mem_wd, e_wd);
        chk("mem_Funct3", mem_Funct3, e_f3);
        chk("fence_done", fence_done, e_fd);
    endtask

    task automatic adv();
        bit   do_enq, do_drain, was_empty, fence_s;
        ent_t ne;
        do_enq    = st_valid && e_st_ready;
        do_drain  = e_wr;
        was_empty = (q.size() == 0);
        fence_s   = fence;
        ne.addr = st_addr; ne.data = st_data; ne.f3 = st_funct3;
        @(posedge clk);
        if (do_drain) q.delete(0);
        if (do_enq) q.push_back(ne);
        case (m_mode)
            0: if (fence_s) m_mode = 1;
            1: if (was_empty) m_mode = 2;
            default: m_mode = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        adv();
    endtask

    task automatic idle();
        st_valid = 0; st_addr = '0; st_data = '0; st_funct3 = '0;
        ld_valid = 0; ld_addr = '0; ld_funct3 = '0; fence = 0;
    endtask

    task automatic store(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f);
        st_valid = 1; st_addr = a; st_data = d; st_funct3 = f;
    endtask

    task automatic load(input logic [8:0] a, input logic [2:0] f);
        ld_valid = 1; ld_addr = a; ld_funct3 = f;
    endtask

    task automatic hard_reset();
        rst_n = 0;
        idle();
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_wr", mem_MemWrite, 0);
        chk("rst_rd", mem_MemRead, 0);
        chk("rst_fence_done", fence_done, 0);
        q.delete();
        m_mode = 0;
        @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        n_checks = 0; n_fail = 0; m_mode = 0;
        idle();
        rst_n = 0;
        @(negedge clk);
        hard_reset();
        #1;
        chk("post_rst_st_ready", st_ready, 1);
        chk("post_rst_empty", empty, 1);

        // Three back-to-back SW, drains on cycles 2-4
        store(9'h010, 32'h1, 3'b010); step();
        store(9'h014, 32'h2, 3'b010); eval();
        chk("drain1_wr", mem_MemWrite, 1); chk("drain1_a", mem_a, 9'h010); adv();
        store(9'h018, 32'h3, 3'b010); eval();
        chk("drain2_a", mem_a, 9'h014); adv();
        idle(); eval();
        chk("drain3_a", mem_a, 9'h018); chk("drain3_wd", mem_wd, 32'h3); adv();
        eval(); chk("drain_done_count", count, 0); chk("drain_done_wr", mem_MemWrite, 0); adv();

        // Fill while an unrelated load holds the port
        load(9'h100, 3'b010);
        for (int i = 0; i < DEPTH; i++) begin
            store(9'h040 + 9'(4 * i), 32'hA0 + 32'(i), 3'b010);
            eval(); chk("fill_no_wr", mem_MemWrite, 0); adv();
        end
        store(9'h050, 32'hBAD, 3'b010); eval();
        chk("fill_full", full, 1); chk("fill_st_ready", st_ready, 0);
        chk("fill_rd", mem_MemRead, 1); chk("fill_no_wr5", mem_MemWrite, 0); adv();
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            eval(); chk("fill_drain_a", mem_a, 9'h040 + 9'(4 * i)); adv();
        end
        step();

        // Youngest SW forwards to LW
        load(9'h100, 3'b010);
        store(9'h020, 32'hDEADBEEF, 3'b010); step();
        store(9'h020, 32'h12345678, 3'b010); step();
        idle(); load(9'h020, 3'b010); eval();
        chk("fwd_hit_lit", fwd_hit, 1); chk("fwd_data_lit", fwd_data, 32'h12345678);
        chk("fwd_no_rd", mem_MemRead, 0); adv();
        idle(); step(); step();

        // Sub-word store blocks a word load until it drains
        store(9'h021, 32'hAB, 3'b000); step();
        idle(); load(9'h020, 3'b010); eval();
        chk("stall_lit", ld_stall, 1); chk("stall_drain_a", mem_a, 9'h021); adv();
        eval();
        chk("stall_clear", ld_stall, 0); chk("stall_rd", mem_MemRead, 1);
        chk("stall_rd_a", mem_a, 9'h020); adv();
        idle(); step();

        // Fence with two buffered stores
        load(9'h100, 3'b010);
        store(9'h060, 32'h60, 3'b010); step();
        store(9'h064, 32'h64, 3'b010); step();
        idle(); fence = 1; eval(); chk("fence_wr0", mem_MemWrite, 1); adv();
        fence = 0; eval();
        chk("fence_st_ready", st_ready, 0); chk("fence_wr1", mem_MemWrite, 1); adv();
        eval(); chk("fence_empty", count, 0); chk("fence_fd0", fence_done, 0); adv();
        eval(); chk("fence_done_pulse", fence_done, 1); chk("fence_done_ready", st_ready, 0); adv();
        eval(); chk("fence_done_off", fence_done, 0); chk("fence_ready_back", st_ready, 1); adv();

        // Fence while already empty
        fence = 1; eval(); adv();
        fence = 0; eval(); chk("efence_fd1", fence_done, 0); adv();
        eval(); chk("efence_fd2", fence_done, 1); adv();
        step();

        // Asynchronous reset while draining three entries
        load(9'h100, 3'b010);
        for (int i = 0; i < 3; i++) begin
            store(9'h080 + 9'(4 * i), 32'h80 + 32'(i), 3'b010); step();
        end
        idle(); eval();
        chk("mid_count", count, 3); chk("mid_wr", mem_MemWrite, 1);
        rst_n = 0;
        #1;
        chk("async_count", count, 0); chk("async_wr", mem_MemWrite, 0);
        q.delete(); m_mode = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            eval(); chk("post_rst_no_wr", mem_MemWrite, 0); adv();
        end

        // Randomized traffic over a narrow address window to force matches
        for (int n = 0; n < 2000; n++) begin
            st_valid  = ($urandom_range(0, 99) < 55);
            st_addr   = 9'h020 + 9'($urandom_range(0, 15));
            st_data   = $urandom;
            st_funct3 = 3'($urandom_range(0, 2));
            ld_valid  = ($urandom_range(0, 99) < 45);
            ld_addr   = 9'h020 + 9'($urandom_range(0, 19));
            case ($urandom_range(0, 4))
                0: ld_funct3 = 3'b000;
                1: ld_funct3 = 3'b001;
                2: ld_funct3 = 3'b100;
                3: ld_funct3 = 3'b101;
                default: ld_funct3 = 3'b010;
            endcase
            fence = ($urandom_range(0, 39) == 0);
            step();
        end
        idle();
        for (int i = 0; i < 8; i++) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
